// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, E pipeline register payload and condition helpers.
package y86_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned STAT_W = 3;
    localparam int unsigned CC_W   = 3;

    typedef enum logic [CODE_W-1:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [CODE_W-1:0] {
        A_ADD = 4'h0,
        A_SUB = 4'h1,
        A_AND = 4'h2,
        A_XOR = 4'h3,
        A_SHL = 4'h4,
        A_SAR = 4'h5
    } alufun_e;

    typedef enum logic [CODE_W-1:0] {
        C_ALWAYS = 4'h0,
        C_LE     = 4'h1,
        C_L      = 4'h2,
        C_E      = 4'h3,
        C_NE     = 4'h4,
        C_GE     = 4'h5,
        C_G      = 4'h6
    } cond_e;

    typedef enum logic [STAT_W-1:0] {
        S_BUB = 3'd0,
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_e;

    localparam logic [CODE_W-1:0] RNONE     = 4'hF;
    localparam logic [WORD_W-1:0] STACK_DEC = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [WORD_W-1:0] STACK_INC = 64'h0000_0000_0000_0008;

    typedef struct packed {
        logic [STAT_W-1:0] stat;
        logic [WORD_W-1:0] pc;
        logic [CODE_W-1:0] icode;
        logic [CODE_W-1:0] ifun;
        logic [WORD_W-1:0] valC;
        logic [WORD_W-1:0] valA;
        logic [WORD_W-1:0] valB;
        logic [CODE_W-1:0] dstE;
        logic [CODE_W-1:0] dstM;
        logic [CODE_W-1:0] srcA;
        logic [CODE_W-1:0] srcB;
    } eReg_t;

    localparam eReg_t E_BUBBLE = '{
        stat:  S_BUB,
        pc:    '0,
        icode: I_NOP,
        ifun:  '0,
        valC:  '0,
        valA:  '0,
        valB:  '0,
        dstE:  RNONE,
        dstM:  RNONE,
        srcA:  RNONE,
        srcB:  RNONE
    };

    // Downstream exception statuses freeze the condition codes.
    function automatic logic isException(input logic [STAT_W-1:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

    // cc is {ZF,SF,OF}; undefined condition codes evaluate false.
    function automatic logic condEval(input logic [CC_W-1:0] cc, input logic [CODE_W-1:0] ifun);
        logic zf, sf, of;
        logic res;
        {zf, sf, of} = cc;
        res = 1'b0;
        case (ifun)
            C_ALWAYS: res = 1'b1;
            C_LE:     res = (sf ^ of) | zf;
            C_L:      res = sf ^ of;
            C_E:      res = zf;
            C_NE:     res = ~zf;
            C_GE:     res = ~(sf ^ of);
            C_G:      res = ~(sf ^ of) & ~zf;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU producing valE and candidate {ZF,SF,OF}.
// ALU_SHIFT_EN adds SHL/SAR as alufun 4/5.
module y86_alu
    import y86_pkg::*;
(
    input  logic [WORD_W-1:0] aluA,
    input  logic [WORD_W-1:0] aluB,
    input  logic [CODE_W-1:0] aluFun,
    output logic [WORD_W-1:0] valE,
    output logic [CC_W-1:0]   flags,
    output logic              legal
);

    logic ovf;

    // Unsupported functions yield zero and are flagged so the caller can block CC update.
    always_comb begin
        valE  = '0;
        ovf   = 1'b0;
        legal = 1'b1;
        case (aluFun)
            A_ADD: begin
                valE = aluB + aluA;
                ovf  = (aluA[WORD_W-1] == aluB[WORD_W-1]) && (valE[WORD_W-1] != aluB[WORD_W-1]);
            end
            A_SUB: begin
                valE = aluB - aluA;
                ovf  = (aluA[WORD_W-1] != aluB[WORD_W-1]) && (valE[WORD_W-1] != aluB[WORD_W-1]);
            end
            A_AND: valE = aluB & aluA;
            A_XOR: valE = aluB ^ aluA;
`ifdef ALU_SHIFT_EN
            A_SHL: valE = aluB << aluA[5:0];
            A_SAR: valE = WORD_W'($signed(aluB) >>> aluA[5:0]);
`endif
            default: legal = 1'b0;
        endcase
    end

    assign flags = {(valE == '0), valE[WORD_W-1], ovf};

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU operand muxing, CC register and branch/cmov condition.
// Optional feature macro: ALU_SHIFT_EN (enables OPQ shift functions in y86_alu).
module execute_stage
    import y86_pkg::*;
#(
    parameter int unsigned       DATA_W = 64,
    parameter logic [CC_W-1:0]   CC_RST = 3'b100
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              E_stall_i,
    input  logic              E_bubble_i,
    input  logic [2:0]        d_stat_i,
    input  logic [DATA_W-1:0] d_pc_i,
    input  logic [3:0]        d_icode_i,
    input  logic [3:0]        d_ifun_i,
    input  logic [DATA_W-1:0] d_valC_i,
    input  logic [DATA_W-1:0] d_valA_i,
    input  logic [DATA_W-1:0] d_valB_i,
    input  logic [3:0]        d_dstE_i,
    input  logic [3:0]        d_dstM_i,
    input  logic [3:0]        d_srcA_i,
    input  logic [3:0]        d_srcB_i,
    input  logic [2:0]        m_stat_i,
    input  logic [2:0]        W_stat_i,
    output logic [2:0]        E_stat_o,
    output logic [DATA_W-1:0] E_pc_o,
    output logic [3:0]        E_icode_o,
    output logic [3:0]        E_ifun_o,
    output logic [DATA_W-1:0] E_valA_o,
    output logic [3:0]        E_dstM_o,
    output logic [3:0]        E_srcA_o,
    output logic [3:0]        E_srcB_o,
    output logic [DATA_W-1:0] e_valE_o,
    output logic [3:0]        e_dstE_o,
    output logic              e_cnd_o,
    output logic [2:0]        cc_o
);

    eReg_t             eReg;
    eReg_t             eNext;
    logic [CC_W-1:0]   ccReg;
    logic [WORD_W-1:0] aluA;
    logic [WORD_W-1:0] aluB;
    logic [CODE_W-1:0] aluFun;
    logic [WORD_W-1:0] aluOut;
    logic [CC_W-1:0]   aluFlags;
    logic              aluLegal;
    logic              isOpq;
    logic              setCc;
    logic              cnd;

    // Stall holds, bubble injects a NOP, otherwise capture decode.
    always_comb begin
        eNext = eReg;
        if (!E_stall_i) begin
            if (E_bubble_i) begin
                eNext = E_BUBBLE;
            end else begin
                eNext = '{
                    stat:  d_stat_i,
                    pc:    d_pc_i,
                    icode: d_icode_i,
                    ifun:  d_ifun_i,
                    valC:  d_valC_i,
                    valA:  d_valA_i,
                    valB:  d_valB_i,
                    dstE:  d_dstE_i,
                    dstM:  d_dstM_i,
                    srcA:  d_srcA_i,
                    srcB:  d_srcB_i
                };
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            eReg <= E_BUBBLE;
        end else begin
            eReg <= eNext;
        end
    end

    always_comb begin
        aluA = '0;
        case (eReg.icode)
            I_OPQ, I_RRMOVQ:             aluA = eReg.valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: aluA = eReg.valC;
            I_CALL, I_PUSHQ:             aluA = STACK_DEC;
            I_RET, I_POPQ:               aluA = STACK_INC;
            default:                     aluA = '0;
        endcase
    end

    always_comb begin
        aluB = '0;
        case (eReg.icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: aluB = eReg.valB;
            default:                                                    aluB = '0;
        endcase
    end

    assign isOpq  = (eReg.icode == I_OPQ);
    assign aluFun = isOpq ? eReg.ifun : A_ADD;

    y86_alu u_alu (
        .aluA   (aluA),
        .aluB   (aluB),
        .aluFun (aluFun),
        .valE   (aluOut),
        .flags  (aluFlags),
        .legal  (aluLegal)
    );

    // A held OPQ keeps rewriting the same flags, so stall needs no gating here.
    assign setCc = isOpq && aluLegal && !isException(m_stat_i) && !isException(W_stat_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ccReg <= CC_RST;
        end else if (setCc) begin
            ccReg <= aluFlags;
        end
    end

    assign cnd = condEval(ccReg, eReg.ifun);

    assign E_stat_o  = eReg.stat;
    assign E_pc_o    = eReg.pc;
    assign E_icode_o = eReg.icode;
    assign E_ifun_o  = eReg.ifun;
    assign E_valA_o  = eReg.valA;
    assign E_dstM_o  = eReg.dstM;
    assign E_srcA_o  = eReg.srcA;
    assign E_srcB_o  = eReg.srcB;
    assign e_valE_o  = aluOut;
    assign e_cnd_o   = cnd;
    assign e_dstE_o  = ((eReg.icode == I_RRMOVQ) && !cnd) ? RNONE : eReg.dstE;
    assign cc_o      = ccReg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: E register control, ALU results, CC gating and cmov/jXX conditions.
module tb_execute_stage;

    logic        clk_i;
    logic        rst_n_i;
    logic        E_stall_i;
    logic        E_bubble_i;
    logic [2:0]  d_stat_i;
    logic [63:0] d_pc_i;
    logic [3:0]  d_icode_i;
    logic [3:0]  d_ifun_i;
    logic [63:0] d_valC_i;
    logic [63:0] d_valA_i;
    logic [63:0] d_valB_i;
    logic [3:0]  d_dstE_i;
    logic [3:0]  d_dstM_i;
    logic [3:0]  d_srcA_i;
    logic [3:0]  d_srcB_i;
    logic [2:0]  m_stat_i;
    logic [2:0]  W_stat_i;
    logic [2:0]  E_stat_o;
    logic [63:0] E_pc_o;
    logic [3:0]  E_icode_o;
    logic [3:0]  E_ifun_o;
    logic [63:0] E_valA_o;
    logic [3:0]  E_dstM_o;
    logic [3:0]  E_srcA_o;
    logic [3:0]  E_srcB_o;
    logic [63:0] e_valE_o;
    logic [3:0]  e_dstE_o;
    logic        e_cnd_o;
    logic [2:0]  cc_o;

    int          testCnt = 0;
    int          failCnt = 0;
    logic [63:0] pcNext  = 64'h40;
    logic [63:0] heldPc;

    execute_stage dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .E_stall_i  (E_stall_i),
        .E_bubble_i (E_bubble_i),
        .d_stat_i   (d_stat_i),
        .d_pc_i     (d_pc_i),
        .d_icode_i  (d_icode_i),
        .d_ifun_i   (d_ifun_i),
        .d_valC_i   (d_valC_i),
        .d_valA_i   (d_valA_i),
        .d_valB_i   (d_valB_i),
        .d_dstE_i   (d_dstE_i),
        .d_dstM_i   (d_dstM_i),
        .d_srcA_i   (d_srcA_i),
        .d_srcB_i   (d_srcB_i),
        .m_stat_i   (m_stat_i),
        .W_stat_i   (W_stat_i),
        .E_stat_o   (E_stat_o),
        .E_pc_o     (E_pc_o),
        .E_icode_o  (E_icode_o),
        .E_ifun_o   (E_ifun_o),
        .E_valA_o   (E_valA_o),
        .E_dstM_o   (E_dstM_o),
        .E_srcA_o   (E_srcA_o),
        .E_srcB_o   (E_srcB_o),
        .e_valE_o   (e_valE_o),
        .e_dstE_o   (e_dstE_o),
        .e_cnd_o    (e_cnd_o),
        .cc_o       (cc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] valA, input logic [63:0] valB,
                         input logic [63:0] valC, input logic [3:0] dstE);
        d_stat_i  = 3'd1;
        d_pc_i    = pcNext;
        pcNext    = pcNext + 64'd10;
        d_icode_i = icode;
        d_ifun_i  = ifun;
        d_valA_i  = valA;
        d_valB_i  = valB;
        d_valC_i  = valC;
        d_dstE_i  = dstE;
        d_dstM_i  = 4'hF;
        d_srcA_i  = 4'h5;
        d_srcB_i  = 4'h6;
    endtask

    task automatic driveNop();
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i    = 1'b1;
        E_stall_i  = 1'b0;
        E_bubble_i = 1'b0;
        m_stat_i   = 3'd1;
        W_stat_i   = 3'd1;
        driveNop();

        // Asynchronous reset before any clock edge
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_icode", 64'(E_icode_o), 64'h1);
        check("rst_dstE",  64'(e_dstE_o),  64'hF);
        check("rst_cc",    64'(cc_o),      64'h4);
        check("rst_stat",  64'(E_stat_o),  64'h0);
        check("rst_valE",  e_valE_o,       64'h0);
        check("rst_srcA",  64'(E_srcA_o),  64'hF);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // OPQ sub 3-3 -> zero
        d_pc_i = 64'h0;
        drive(4'h6, 4'h1, 64'd3, 64'd3, 64'h0, 4'h2);
        heldPc = d_pc_i;
        tick();
        check("sub0_valE",  e_valE_o,       64'h0);
        check("sub0_dstE",  64'(e_dstE_o),  64'h2);
        check("sub0_icode", 64'(E_icode_o), 64'h6);
        check("sub0_ifun",  64'(E_ifun_o),  64'h1);
        check("sub0_pc",    E_pc_o,         heldPc);
        check("sub0_valA",  E_valA_o,       64'd3);
        check("sub0_srcA",  64'(E_srcA_o),  64'h5);
        check("sub0_srcB",  64'(E_srcB_o),  64'h6);
        check("sub0_dstM",  64'(E_dstM_o),  64'hF);
        check("sub0_stat",  64'(E_stat_o),  64'h1);
        driveNop();
        tick();
        check("sub0_cc", 64'(cc_o), 64'h4);

        // OPQ sub 0-1 -> negative
        drive(4'h6, 4'h1, 64'd1, 64'd0, 64'h0, 4'h2);
        tick();
        check("subneg_valE", e_valE_o, 64'hFFFF_FFFF_FFFF_FFFF);
        driveNop();
        tick();
        check("subneg_cc", 64'(cc_o), 64'h2);

        // OPQ add signed overflow
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h3);
        tick();
        check("addovf_valE", e_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
        driveNop();
        tick();
        check("addovf_cc", 64'(cc_o), 64'h3);

        // Memory-stage ADR blocks CC update
        m_stat_i = 3'd3;
        drive(4'h6, 4'h1, 64'd1, 64'd0, 64'h0, 4'h2);
        tick();
        check("madr_valE", e_valE_o, 64'hFFFF_FFFF_FFFF_FFFF);
        driveNop();
        tick();
        check("madr_cc", 64'(cc_o), 64'h3);
        m_stat_i = 3'd1;

        // Write-back HLT blocks CC update
        W_stat_i = 3'd2;
        drive(4'h6, 4'h1, 64'd3, 64'd3, 64'h0, 4'h2);
        tick();
        driveNop();
        tick();
        check("whlt_cc", 64'(cc_o), 64'h3);
        W_stat_i = 3'd1;

        // cmovle with cc=000 -> move suppressed
        drive(4'h6, 4'h0, 64'd1, 64'd1, 64'h0, 4'h2);
        tick();
        drive(4'h2, 4'h1, 64'h55, 64'h0, 64'h0, 4'h3);
        tick();
        check("cmov0_cc",   64'(cc_o),     64'h0);
        check("cmov0_cnd",  64'(e_cnd_o),  64'h0);
        check("cmov0_dstE", 64'(e_dstE_o), 64'hF);
        check("cmov0_valE", e_valE_o,      64'h55);

        // cmovle with cc=100 -> move taken
        drive(4'h6, 4'h1, 64'd3, 64'd3, 64'h0, 4'h2);
        tick();
        drive(4'h2, 4'h1, 64'h55, 64'h0, 64'h0, 4'h3);
        tick();
        check("cmov1_cc",   64'(cc_o),     64'h4);
        check("cmov1_cnd",  64'(e_cnd_o),  64'h1);
        check("cmov1_dstE", 64'(e_dstE_o), 64'h3);

        // Jump conditions against cc=100
        drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h200, 4'hF);
        tick();
        check("jl_cnd", 64'(e_cnd_o), 64'h0);
        drive(4'h7, 4'h3, 64'h0, 64'h0, 64'h200, 4'hF);
        tick();
        check("je_cnd", 64'(e_cnd_o), 64'h1);
        drive(4'h7, 4'h7, 64'h0, 64'h0, 64'h200, 4'hF);
        tick();
        check("jbad_cnd", 64'(e_cnd_o), 64'h0);

        // Stack pointer arithmetic, CC untouched
        drive(4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
        tick();
        check("push_valE", e_valE_o, 64'hF8);
        drive(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
        heldPc = d_pc_i;
        tick();
        check("pop_valE", e_valE_o,      64'h108);
        check("pop_cc",   64'(cc_o),     64'h4);

        // Stall wins over bubble
        E_stall_i  = 1'b1;
        E_bubble_i = 1'b1;
        drive(4'h6, 4'h0, 64'd9, 64'd9, 64'h0, 4'h2);
        tick();
        check("stall_icode", 64'(E_icode_o), 64'hB);
        check("stall_pc",    E_pc_o,         heldPc);
        check("stall_valE",  e_valE_o,       64'h108);

        // Bubble only
        E_stall_i = 1'b0;
        tick();
        check("bub_icode", 64'(E_icode_o), 64'h1);
        check("bub_stat",  64'(E_stat_o),  64'h0);
        check("bub_dstE",  64'(e_dstE_o),  64'hF);
        check("bub_valE",  e_valE_o,       64'h0);
        E_bubble_i = 1'b0;

        // OPQ ifun 4: shift when enabled, illegal otherwise
        drive(4'h6, 4'h4, 64'd4, 64'd1, 64'h0, 4'h2);
        tick();
        driveNop();
`ifdef ALU_SHIFT_EN
        check("shl_valE", e_valE_o, 64'h10);
        tick();
        check("shl_cc", 64'(cc_o), 64'h0);
`else
        check("ill4_valE", e_valE_o, 64'h0);
        tick();
        check("ill4_cc", 64'(cc_o), 64'h4);
`endif

        // Always-illegal OPQ ifun 7
        drive(4'h6, 4'h7, 64'd1, 64'd0, 64'h0, 4'h2);
        tick();
        check("ill7_valE", e_valE_o, 64'h0);

        // Reset mid-operation discards E and restores CC
        drive(4'h6, 4'h1, 64'd1, 64'd0, 64'h0, 4'h2);
        tick();
        drive(4'h6, 4'h0, 64'd5, 64'd6, 64'h0, 4'h2);
        tick();
        check("pre_rst_cc", 64'(cc_o), 64'h2);
        #2 rst_n_i = 1'b0;
        #1;
        check("midrst_icode", 64'(E_icode_o), 64'h1);
        check("midrst_cc",    64'(cc_o),      64'h4);
        check("midrst_valE",  e_valE_o,       64'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
